// File: rtl/dmem_responder_pkg.sv
// Shared pipeline-wide definitions for the multi-cycle data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned WORD_OFS   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage load/store handshake between the pipeline and the data-memory responder.
interface dmem_responder_if #(
  parameter int unsigned DATA_W = dmem_responder_pkg::DATA_W_DEF
);
  logic              mem_r_en;
  logic              mem_w_en;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              freeze_req;
  logic              err;

  modport master (
    output mem_r_en, mem_w_en, addr, wdata,
    input  rdata, ready, freeze_req, err
  );

  modport slave (
    input  mem_r_en, mem_w_en, addr, wdata,
    output rdata, ready, freeze_req, err
  );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word storage: synchronous write, combinational read, async active-low clear.
module dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IW-1:0]     widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IW-1:0]     ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: latches a MEM-stage request, holds the pipeline
// frozen for LATENCY wait cycles, then performs the access and pulses ready.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_w_q, op_w_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req;
  logic              misaligned;
  logic              we;
  logic [DATA_W-1:0] rd_word;

  assign req        = bus.mem_r_en | bus.mem_w_en;
  assign misaligned = bus.addr[WORD_OFS-1:0] != '0;

  if (DATA_W > WORD_OFS + IW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[DATA_W-1:WORD_OFS+IW];
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IW     (IW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .widx  (idx_q),
    .wdata (wdata_q),
    .ridx  (idx_q),
    .rdata (rd_word)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_w_d         = op_w_q;
    idx_d          = idx_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    we             = 1'b0;
    bus.ready      = 1'b0;
    bus.freeze_req = 1'b0;
    bus.rdata      = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          bus.freeze_req = 1'b1;
          op_w_d         = bus.mem_w_en;
          idx_d          = bus.addr[WORD_OFS +: IW];
          wdata_d        = bus.wdata;
          cnt_d          = CNT_W'(LATENCY - 1);
          state_d        = ST_WAIT;
          if ((bus.mem_r_en & bus.mem_w_en) | misaligned) begin
            err_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        bus.freeze_req = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          we      = op_w_q;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // Read data goes out combinationally now and is captured so it holds afterwards.
        bus.ready = 1'b1;
        rdata_d   = op_w_q ? wdata_q : rd_word;
        bus.rdata = rdata_d;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    bus.err = err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_w_q  <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_w_q  <= op_w_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes expected responses from a word-array
// model, a negedge monitor pops and compares whenever ready is seen.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if #(.DATA_W(DW)) bus ();

  dmem_responder #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [DEPTH];
  logic        err_m;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.ready !== 1'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", {31'd0, bus.ready}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_rdata"}, bus.rdata, e.rdata);
        chk({e.tag, "_err"}, {31'd0, bus.err}, {31'd0, e.err});
        chk({e.tag, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    err_m = 1'b0;
  endtask

  task automatic drive_idle();
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the pipeline advances.
  task automatic issue(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input bit perturb, input string tag);
    exp_t e;
    int   idx;
    idx = (a / 4) % DEPTH;
    if ((r && w) || (a % 4 != 0)) err_m = 1'b1;
    e.rdata = w ? d : mem_m[idx];
    if (w) mem_m[idx] = d;
    e.err = err_m;
    e.cyc = cyc + LAT + 1;
    e.tag = tag;
    sb.push_back(e);
    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.addr     = a;
    bus.wdata    = d;
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      chk({tag, "_freeze"}, {31'd0, bus.freeze_req}, {31'd0, (k <= LAT)});
      @(posedge clk);
      #1;
      if (perturb && k == 1) begin
        bus.mem_r_en = 1'($urandom_range(0, 1));
        bus.mem_w_en = 1'($urandom_range(0, 1));
        bus.addr     = $urandom;
        bus.wdata    = $urandom;
      end
    end
    drive_idle();
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    drive_idle();
    model_clear();
    idle(2);
    rst = 1'b1;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        r, w;
    logic [31:0] a, d;

    rst = 1'b0;
    drive_idle();
    model_clear();
    idle(3);
    rst = 1'b1;
    idle(1);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_ready", {31'd0, bus.ready}, 32'd0);
    chk("reset_freeze", {31'd0, bus.freeze_req}, 32'd0);
    chk("reset_err", {31'd0, bus.err}, 32'd0);

    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "store10");
    issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "load10");
    issue(1'b0, 1'b1, 32'h100, 32'h12345678, 1'b0, "store100");
    issue(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "load_wrap");
    issue(1'b0, 1'b1, 32'h20, 32'hA5A5_0F0F, 1'b0, "store20");
    issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, "load20_perturb");
    issue(1'b0, 1'b1, 32'h24, 32'h0BAD_CAFE, 1'b1, "store24_perturb");
    issue(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, "load24");

    for (int i = 0; i < 30; i++) begin
      w = 1'($urandom_range(0, 1));
      r = ~w;
      a = 32'($urandom_range(0, 255)) * 4;
      d = $urandom;
      issue(r, w, a, d, 1'($urandom_range(0, 1)), "rand");
      idle($urandom_range(0, 2));
    end
    chk("err_clean", {31'd0, bus.err}, 32'd0);

    pulse_reset();
    issue(1'b0, 1'b1, 32'h6, 32'h1357_9BDF, 1'b0, "store_misaligned");
    issue(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, "load_idx1");

    pulse_reset();
    issue(1'b1, 1'b1, 32'h8, 32'h55, 1'b0, "both_en");
    issue(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, "load8");
    issue(1'b0, 1'b1, 32'h30, 32'h7777_0000, 1'b0, "clean_after_err");
    idle(2);
    chk("err_sticky", {31'd0, bus.err}, 32'd1);

    pulse_reset();
    issue(1'b0, 1'b1, 32'h4, 32'h1111_2222, 1'b0, "pre_store4");
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b1;
    bus.addr     = 32'h4;
    bus.wdata    = 32'hCAFE_F00D;
    idle(2);
    rst = 1'b0;
    drive_idle();
    model_clear();
    #1;
    chk("midrst_freeze", {31'd0, bus.freeze_req}, 32'd0);
    chk("midrst_ready", {31'd0, bus.ready}, 32'd0);
    chk("midrst_err", {31'd0, bus.err}, 32'd0);
    idle(2);
    rst = 1'b1;
    idle(LAT + 3);
    chk("midrst_freeze_after", {31'd0, bus.freeze_req}, 32'd0);
    issue(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, "load4_after_rst");

    idle(5);
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder that answers the MEM-stage load/store requests issued by the pipeline datapath.
- Latches a request, waits a fixed latency, then performs the access and returns read data.
- Raises freeze_req for the whole access so the datapath's hazard/freeze logic stalls all stages.
- Replaces the single-cycle data memory when the memory latency is greater than one cycle.

Parameters:
- DATA_W, 32, data and address width in bits.
- DEPTH, 64, number of words of storage (power of two).
- LATENCY, 3, wait cycles between request acceptance and response (must be ≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_r_en  input  1  load request from MEM stage.
- mem_w_en  input  1  store request from MEM stage.
- addr  input  DATA_W  byte address (ALU result).
- wdata  input  DATA_W  store data.
- rdata  output  DATA_W  load data, valid while ready=1.
- ready  output  1  one-cycle completion pulse.
- freeze_req  output  1  pipeline freeze request.
- err  output  1  sticky error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, rdata=0, ready=0, freeze_req=0, err=0, all storage words=0.
  - Reset mid-access aborts the access: no write occurs and the pipeline is released immediately.
- Word index = addr[2 +: log2(DEPTH)]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- FSM states:
  - IDLE:
    - If mem_r_en or mem_w_en: latch op, addr and wdata; counter ← LATENCY-1; go to WAIT.
    - freeze_req is driven combinationally from the request, so it is high in the same cycle the request appears.
  - WAIT:
    - freeze_req=1.
    - If counter≠0, decrement.
    - If counter=0, go to RESP. For a store, write the latched wdata at this edge.
  - RESP:
    - ready=1 and freeze_req=0 for exactly one cycle.
    - Load: rdata = word at the latched index. Store: rdata = latched wdata.
    - Next state is always IDLE.
    - The request still visible on the inputs during RESP is the consumed one and is ignored; the pipeline advances at the RESP→IDLE edge.
- Latency: the request is accepted in cycle 0 and ready is high in cycle LATENCY+1. freeze_req is high in cycles 0..LATENCY inclusive.
- Back-to-back requests: a new request in the cycle after RESP is accepted normally. The minimum spacing between ready pulses is LATENCY+2 cycles.
- Inputs are sampled only at acceptance; changes during WAIT are ignored.
- Both mem_r_en and mem_w_en high at acceptance: treated as a store, err←1.
- Misaligned address (addr[1:0]≠0) at acceptance: access proceeds on the word index, err←1.
- err stays set until reset.
- rdata holds its last value outside RESP.

Decomposition:
- Shared package (pipeline-wide):
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - DATA_W default.
  - Word-offset constant 2.
- One sub-module: dmem_array (DEPTH×DATA_W storage).
  - Synchronous write, combinational read.
  - Asynchronous active-low clear.
- The FSM and counter live in dmem_responder.

Test Plan:
- Reset value: hold rst=0, then release → rdata=0, ready=0, freeze_req=0, err=0.
- Store then load:
  - Store addr=0x10, wdata=0xDEADBEEF → freeze_req high for cycles 0..3, ready pulse in cycle 4.
  - Next load from addr=0x10 → rdata=0xDEADBEEF with ready in cycle 4.
- Wrap-around: store 0x12345678 to addr=0x100 (index 0) → a load from addr=0x0 returns 0x12345678.
- Input change during WAIT: request at 0x20, then change addr/wdata/enables in cycle 2 → the original 0x20 access completes unchanged, ready in cycle 4.
- Error cases:
  - mem_r_en=mem_w_en=1 at addr=0x8, wdata=0x55 → store performed, err=1.
  - Misaligned addr=0x6 → err=1, index 1 accessed.
  - err remains 1 after a subsequent clean access.
- Reset mid-access: assert rst=0 in cycle 2 of a store to 0x4 → freeze_req drops immediately, no ready pulse, and a later load of 0x4 returns 0.
